// File: rtl/uart_ctrl.sv
// uart_ctrl: register-mapped UART controller with rx FIFO, tx holding register and tx handshake FSM
module uart_ctrl #(
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        as,
    input  logic        rw,
    input  logic        addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy,
    input  logic        rx_busy,
    input  logic        rx_end,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        tx_end,
    output logic        irq_rx,
    output logic        irq_tx
);
    localparam int PW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RX_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    logic [7:0]    mem [RX_FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          rx_overrun, tx_done, rx_ie, tx_ie, tx_overflow, tx_pending;
    logic [7:0]    tx_hold;
    state_t        state, state_nx;
    logic          acc, rd_acc, stat_wr, data_wr, pop, push, launch, done_evt;
    logic [31:0]   status, rd_val;
    logic          unused_in;

    assign unused_in = ^{rx_busy, wr_data[31:8]};
    assign acc       = cs & as;
    assign rd_acc    = acc & rw;
    assign stat_wr   = acc & ~rw & ~addr;
    assign data_wr   = acc & ~rw & addr;
    assign pop       = rd_acc & addr & (count != '0);
    // a full FIFO still accepts a byte when the same cycle pops the head
    assign push      = rx_end & ((count != FULL) | pop);
    assign status    = {25'h0, tx_overflow, tx_ie, rx_ie, tx_done, rx_overrun,
                        tx_pending | (state != IDLE), count != '0};
    assign rd_val    = pop ? {24'h0, mem[rd_ptr]} : (rd_acc & ~addr) ? status : 32'h0;
    assign irq_rx    = rx_ie & ((count != '0) | rx_overrun);
    assign irq_tx    = tx_ie & tx_done;

    // bus response: one-cycle rdy with registered read data, zero otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy     <= 1'b0;
            rd_data <= 32'h0;
        end else begin
            rdy     <= acc;
            rd_data <= rd_val;
        end
    end

    // rx FIFO pointers and occupancy; pop is taken before push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // rx FIFO storage needs no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    // status flags, interrupt enables and tx holding register; sticky sets win over clears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ie       <= 1'b0;
            tx_ie       <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_done     <= 1'b0;
            tx_overflow <= 1'b0;
            tx_pending  <= 1'b0;
            tx_hold     <= 8'h0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h0;
        end else begin
            if (stat_wr) begin
                rx_ie <= wr_data[4];
                tx_ie <= wr_data[5];
            end
            rx_overrun  <= (rx_end & ~push) | (rx_overrun & ~(stat_wr & wr_data[2]));
            tx_done     <= done_evt | (tx_done & ~(stat_wr & wr_data[3]));
            tx_overflow <= (data_wr & tx_pending) | (tx_overflow & ~(stat_wr & wr_data[6]));
            tx_pending  <= (data_wr & ~tx_pending) | (tx_pending & ~launch);
            if (data_wr & ~tx_pending) tx_hold <= wr_data[7:0];
            tx_start <= launch;
            if (launch) tx_data <= tx_hold;
        end
    end

    // tx FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end

    // tx FSM next state
    always_comb begin
        state_nx = (state == IDLE && launch)   ? START :
                   (state == START && tx_busy) ? WAIT  :
                   (state == WAIT && tx_end)   ? IDLE  : state;
    end

    // tx FSM outputs: launch a pending byte from IDLE, flag completion from WAIT
    always_comb begin
        launch   = (state == IDLE) & tx_pending & ~tx_busy;
        done_evt = (state == WAIT) & tx_end;
    end
endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter RX_FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have bus ports: cs input 1 select; as input 1 access strobe; rw input 1 (1=read, 0=write); addr input 1 register select; wr_data input 32; rd_data output 32; rdy output 1 access complete.
REQ-005 SHALL have rx-side ports: rx_busy input 1; rx_end input 1 one-cycle byte-received pulse; rx_data input 8 received byte.
REQ-006 SHALL have tx-side ports: tx_start output 1 one-cycle start pulse; tx_data output 8; tx_busy input 1; tx_end input 1 one-cycle done pulse.
REQ-007 SHALL have irq_rx output 1 and irq_tx output 1 level interrupts.

Function
REQ-008 SHALL treat an access as valid when cs=1 and as=1 in a cycle; rdy SHALL be 1 exactly the following cycle, 0 otherwise.
REQ-009 SHALL drive rd_data registered, valid only in the rdy cycle, 32'h0 in all other cycles and for writes.
REQ-010 SHALL map addr=0 STATUS: bit0 rx_avail (FIFO not empty), bit1 tx_active (pending or tx FSM not IDLE), bit2 rx_overrun, bit3 tx_done, bit4 rx_ie, bit5 tx_ie, bit6 tx_overflow, bits 31:7 read 0.
REQ-011 SHALL on STATUS write: bits 4,5 loaded from wr_data; bits 2,3,6 cleared where wr_data bit is 1 (write-1-to-clear); other bits ignored.
REQ-012 SHALL map addr=1 DATA: read returns {24'h0, FIFO head} and pops one entry; read of empty FIFO returns 32'h0 with no pop and no flag change.
REQ-013 SHALL on DATA write load wr_data[7:0] into tx holding register and set tx_pending if tx_pending=0; if tx_pending=1 write SHALL be dropped and tx_overflow set.
REQ-014 SHALL push rx_data into FIFO on each rx_end pulse; push when full SHALL discard the byte and set rx_overrun.
REQ-015 SHALL on simultaneous pop (DATA read) and push when full perform pop then push: count unchanged, no overrun.
REQ-016 SHALL on simultaneous pop and push when count=1 return the old head and leave the new byte as sole entry.
REQ-017 SHALL keep FIFO pointers modulo RX_FIFO_DEPTH with a count 0..RX_FIFO_DEPTH; wrap-around SHALL be seamless.
REQ-018 SHALL sequence TX with FSM IDLE, START, WAIT.
REQ-019 SHALL in IDLE with tx_pending=1 and tx_busy=0: pulse tx_start for one cycle with tx_data=holding register, clear tx_pending, enter START.
REQ-020 SHALL in START move to WAIT when tx_busy=1; in WAIT on tx_end set tx_done and return to IDLE.
REQ-021 SHALL hold tx_data stable from the tx_start cycle until return to IDLE.
REQ-022 SHALL allow a new DATA write during START/WAIT to set tx_pending, sent on the next IDLE pass (back-to-back bytes).
REQ-023 SHALL on tx_done set and W1C clear in the same cycle give set priority.
REQ-024 SHALL drive irq_rx = rx_ie & (rx_avail | rx_overrun); irq_tx = tx_ie & tx_done; both combinational from registered state.
REQ-025 SHALL ignore rx_busy functionally except as sampled into no register (reserved for future status).

Reset
REQ-026 SHALL on reset=1 immediately force: FIFO empty, pointers 0, tx_pending 0, FSM IDLE, all STATUS bits 0, tx_start 0, tx_data 8'h0, rdy 0, rd_data 32'h0, irq_rx 0, irq_tx 0.
REQ-027 SHALL on reset mid-transmission abandon the byte without a further tx_start after release.
REQ-028 SHALL discard any access in progress at reset; rdy SHALL not assert for it.

Verification
REQ-029 SHALL cover: write DATA 8'hA5 -> tx_start one pulse, tx_data=8'hA5; tx_busy high then tx_end -> STATUS bit3=1; with tx_ie=1 irq_tx=1; W1C 32'h8 -> bit3=0, irq_tx=0.
REQ-030 SHALL cover: rx_end with 8'h11,8'h22,8'h33 -> STATUS bit0=1; three DATA reads return 32'h11,32'h22,32'h33; fourth read returns 32'h0, bit0=0.
REQ-031 SHALL cover: 5 rx_end pulses at depth 4 -> 5th byte lost, bit2=1; reads return first 4 bytes in order.
REQ-032 SHALL cover: FIFO full, DATA read coincident with rx_end 8'h55 -> no overrun, last of next 4 reads = 32'h55.
REQ-033 SHALL cover: two DATA writes while FSM in WAIT -> second dropped, bit6=1; first of them sent after tx_end.
REQ-034 SHALL cover: reset asserted during WAIT with 2 FIFO entries -> all outputs at REQ-026 values same cycle, no tx_start after release.
